// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between the row and column 1D DCT passes: one row in and one column out per cycle.
// Column 0 of a block is presented the cycle after its 8th row is accepted; in_ready drops only while both banks hold undrained blocks.
module dct_transpose_buf #(
   parameter int W = 23,
   parameter int N = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] d0,
   input  logic signed [W-1:0] d1,
   input  logic signed [W-1:0] d2,
   input  logic signed [W-1:0] d3,
   input  logic signed [W-1:0] d4,
   input  logic signed [W-1:0] d5,
   input  logic signed [W-1:0] d6,
   input  logic signed [W-1:0] d7,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] q0,
   output logic signed [W-1:0] q1,
   output logic signed [W-1:0] q2,
   output logic signed [W-1:0] q3,
   output logic signed [W-1:0] q4,
   output logic signed [W-1:0] q5,
   output logic signed [W-1:0] q6,
   output logic signed [W-1:0] q7,
   output logic [2:0]          out_col,
   output logic                out_last
);

   typedef logic signed [W-1:0] elem_t;

   elem_t       mem_q [2][N][N];
   elem_t       din   [N];
   elem_t       col   [N];

   logic [1:0]  full_q,    full_d;
   logic        wr_bank_q, wr_bank_d;
   logic [2:0]  wr_row_q,  wr_row_d;
   logic        rd_bank_q, rd_bank_d;
   logic [2:0]  rd_col_q,  rd_col_d;
   logic        wr_fire;
   logic        rd_fire;

   always_comb begin
      din[0] = d0;
      din[1] = d1;
      din[2] = d2;
      din[3] = d3;
      din[4] = d4;
      din[5] = d5;
      din[6] = d6;
      din[7] = d7;
   end

   assign in_ready  = ~full_q[wr_bank_q];
   assign out_valid = full_q[rd_bank_q];
   assign wr_fire   = in_valid & in_ready;
   assign rd_fire   = out_valid & out_ready;

   // Writer and reader always own different banks, so both full-bit updates can land in one cycle.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      wr_row_d  = wr_row_q;
      rd_bank_d = rd_bank_q;
      rd_col_d  = rd_col_q;
      if (wr_fire) begin
         if (wr_row_q == 3'd7) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_row_d          = 3'd0;
         end else begin
            wr_row_d = wr_row_q + 3'd1;
         end
      end
      if (rd_fire) begin
         if (rd_col_q == 3'd7) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_col_d          = 3'd0;
         end else begin
            rd_col_d = rd_col_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         full_q    <= 2'b00;
         wr_bank_q <= 1'b0;
         wr_row_q  <= 3'd0;
         rd_bank_q <= 1'b0;
         rd_col_q  <= 3'd0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         wr_row_q  <= wr_row_d;
         rd_bank_q <= rd_bank_d;
         rd_col_q  <= rd_col_d;
      end
   end

   // Storage carries no reset; the full flags alone decide what is visible.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int k = 0; k < N; k++) begin
            mem_q[wr_bank_q][wr_row_q][k] <= din[k];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < N; k++) begin
         col[k] = out_valid ? mem_q[rd_bank_q][k][rd_col_q] : '0;
      end
   end

   assign q0       = col[0];
   assign q1       = col[1];
   assign q2       = col[2];
   assign q3       = col[3];
   assign q4       = col[4];
   assign q5       = col[5];
   assign q6       = col[6];
   assign q7       = col[7];
   assign out_col  = rd_col_q;
   assign out_last = out_valid & (rd_col_q == 3'd7);

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed bench for dct_transpose_buf: queued row vectors, a transpose scoreboard and per-cycle handshake checks.
module tb_dct_transpose_buf;

   localparam int W = 23;
   typedef logic [8*W-1:0] vec_t;

   logic                clk = 1'b0;
   logic                reset;
   logic                in_valid;
   logic                in_ready;
   logic                out_valid;
   logic                out_ready;
   logic                out_last;
   logic [2:0]          out_col;
   vec_t                din_v;
   logic signed [W-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
   vec_t                qv;

   always #5 clk = ~clk;

   assign qv = {q7, q6, q5, q4, q3, q2, q1, q0};

   dct_transpose_buf #(.W(W), .N(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d0        (din_v[0*W +: W]),
      .d1        (din_v[1*W +: W]),
      .d2        (din_v[2*W +: W]),
      .d3        (din_v[3*W +: W]),
      .d4        (din_v[4*W +: W]),
      .d5        (din_v[5*W +: W]),
      .d6        (din_v[6*W +: W]),
      .d7        (din_v[7*W +: W]),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q0        (q0),
      .q1        (q1),
      .q2        (q2),
      .q3        (q3),
      .q4        (q4),
      .q5        (q5),
      .q6        (q6),
      .q7        (q7),
      .out_col   (out_col),
      .out_last  (out_last)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input vec_t got, input vec_t exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Bench-side model: rows waiting to be offered, and columns owed by completed blocks.
   vec_t         rowq [$];
   vec_t         expq [$];
   logic [W-1:0] blk [8][8];
   int           mrow;
   int           n_acc, n_xfer, vrun, vrun_max;

   function automatic logic [W-1:0] elem(input int p, input int b, input int r, input int c);
      logic [W-1:0] v;
      case (p)
         0:       v = W'(64 * b + 8 * r + c);
         1:       v = (((r ^ c ^ b) & 1) != 0) ? 23'h3FFFFF : 23'h400000;
         default: v = W'(-(1000 * b + 8 * r + c + 1));
      endcase
      return v;
   endfunction

   task automatic add_block(input int p, input int b);
      for (int r = 0; r < 8; r++) begin
         vec_t row;
         for (int c = 0; c < 8; c++) row[c*W +: W] = elem(p, b, r, c);
         rowq.push_back(row);
      end
   endtask

   task automatic model_accept(input vec_t row);
      for (int c = 0; c < 8; c++) blk[mrow][c] = row[c*W +: W];
      mrow++;
      if (mrow == 8) begin
         mrow = 0;
         for (int c = 0; c < 8; c++) begin
            vec_t colv;
            for (int k = 0; k < 8; k++) colv[k*W +: W] = blk[k][c];
            expq.push_back(colv);
         end
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      din_v     = '0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      rowq.delete();
      expq.delete();
      mrow = 0;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_q", qv, 0);
      check("rst_out_col", out_col, 0);
      check("rst_out_last", out_last, 0);
   endtask

   // rmode: 0 = out_ready high, 1 = out_ready low, 2 = out_ready toggles every cycle.
   task automatic run(input int ncyc, input int rmode, input bit until_done);
      int i;
      i        = 0;
      n_acc    = 0;
      n_xfer   = 0;
      vrun     = 0;
      vrun_max = 0;
      while (i < ncyc && !(until_done && rowq.size() == 0 && expq.size() == 0)) begin
         int   sz;
         bit   exp_rdy, exp_vld, acc, xfer;
         vec_t ecol;
         sz        = expq.size();
         exp_vld   = (sz > 0);
         exp_rdy   = ((sz + 7) / 8) < 2;
         in_valid  = (rowq.size() > 0);
         din_v     = in_valid ? rowq[0] : '0;
         out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : ((i % 2) == 0);
         #1;
         ecol = exp_vld ? expq[0] : '0;
         check("in_ready", in_ready, exp_rdy);
         check("out_valid", out_valid, exp_vld);
         check("col_data", qv, ecol);
         check("out_col", out_col, exp_vld ? (8 - sz % 8) % 8 : 0);
         check("out_last", out_last, exp_vld && (sz % 8 == 1));
         acc  = in_valid && exp_rdy;
         xfer = exp_vld && out_ready;
         vrun = exp_vld ? vrun + 1 : 0;
         if (vrun > vrun_max) vrun_max = vrun;
         @(posedge clk);
         if (xfer) begin
            void'(expq.pop_front());
            n_xfer++;
         end
         if (acc) begin
            model_accept(rowq.pop_front());
            n_acc++;
         end
         @(negedge clk);
         i++;
      end
      if (until_done) check("run_done", rowq.size() + expq.size(), 0);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      din_v     = '0;
      mrow      = 0;
      @(negedge clk);

      // Single block, element (r,c) = 8r+c, streaming.
      do_reset();
      add_block(0, 0);
      run(40, 0, 1);
      check("t1_acc", n_acc, 8);
      check("t1_xfer", n_xfer, 8);

      // Three back-to-back blocks with no bubbles.
      do_reset();
      add_block(0, 1);
      add_block(2, 2);
      add_block(1, 0);
      run(80, 0, 1);
      check("t2_acc", n_acc, 24);
      check("t2_valid_run", vrun_max, 24);

      // Both banks fill under back-pressure; the 17th row waits for block A to drain.
      do_reset();
      add_block(0, 3);
      add_block(2, 4);
      begin
         vec_t extra;
         for (int c = 0; c < 8; c++) extra[c*W +: W] = elem(0, 5, 0, c);
         rowq.push_back(extra);
      end
      run(20, 1, 0);
      check("t3_acc_blocked", n_acc, 16);
      check("t3_row_held", rowq.size(), 1);
      run(60, 0, 1);
      check("t3_acc_after", n_acc, 1);
      check("t3_xfer", n_xfer, 16);

      // Signed extremes pass bit-exact.
      do_reset();
      add_block(1, 0);
      add_block(1, 1);
      run(60, 0, 1);
      check("t4_xfer", n_xfer, 16);

      // Reset with one full block and five rows of the next.
      do_reset();
      add_block(0, 6);
      add_block(0, 7);
      run(13, 1, 0);
      check("t5_acc", n_acc, 13);
      do_reset();
      add_block(2, 8);
      run(40, 0, 1);
      check("t5_xfer", n_xfer, 8);

      // Sink accepts every other cycle across two blocks.
      do_reset();
      add_block(0, 9);
      add_block(2, 10);
      run(120, 2, 1);
      check("t6_xfer", n_xfer, 16);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dct_transpose_buf.md
Name: dct_transpose_buf

Overview:
- Transpose memory between the first (row) and second (column) 8-point 1D DCT passes of the 8x8 2D DCT.
- Sits directly downstream of the 8-point 1D DCT. Accepts one 8-coefficient row per cycle and emits one 8-element column per cycle.
- Ping-pong (two 8x8 banks), so one block fills while the other drains at sustained rate.

Parameters:
- W, 23, signed width of each element (equals the 1D DCT output width w_o = 8 + 13 + 2).
- N, 8, transform size. Fixed at 8; other values unsupported.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  row d0..d7 present this cycle
- in_ready  out  1  buffer can accept a row
- d0..d7  in  W each  signed row element k (from 1D DCT outputs F0..F7)
- out_valid  out  1  column q0..q7 valid
- out_ready  in  1  downstream takes column this cycle
- q0..q7  out  W each  signed column element k (row index k of current column)
- out_col  out  3  index of column currently presented
- out_last  out  1  high with column 7 of a block

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (reset).
- State:
  - mem[2][8][8] of W bits; memory is not reset.
  - full[1:0] flags.
  - wr_bank and 3-bit wr_row.
  - rd_bank and 3-bit rd_col.
- Reset: full=0, wr_bank=0, wr_row=0, rd_bank=0, rd_col=0.
  - Outputs after reset: in_ready=1, out_valid=0, q0..q7=0, out_col=0, out_last=0.
  - Reset mid-operation discards partial and full blocks. No column is emitted after reset until 8 new rows are accepted.
- Write side:
  - in_ready = ~full[wr_bank] (combinational from registers).
  - Accept when in_valid & in_ready: mem[wr_bank][wr_row][k] <= dk for k=0..7, then wr_row++.
  - Accept with wr_row==7: full[wr_bank]<=1, wr_bank toggles, wr_row<=0.
  - in_valid while in_ready=0: row ignored. The upstream stage must hold it.
- Read side:
  - out_valid = full[rd_bank].
  - qk = mem[rd_bank][k][rd_col] when out_valid, else 0.
  - out_col = rd_col. out_last = out_valid & (rd_col==7).
  - Transfer when out_valid & out_ready: rd_col++.
  - Transfer with rd_col==7: full[rd_bank]<=0, rd_bank toggles, rd_col<=0.
  - out_ready while out_valid=0: no effect.
- Latency: column 0 of a block is valid the cycle after its 8th row is accepted.
- Throughput: with out_ready held high, one row in and one column out per cycle, no bubbles, in_ready never drops.
- Simultaneous events:
  - A write completing one bank and a read completing the other bank in the same cycle both update their own full bit. Neither is lost.
  - Read and write never target the same bank at once, because writes need ~full and reads need full.
- Back-pressure: out_ready=0 with both banks full forces in_ready=0 after 16 accepted rows.
- Arithmetic: no arithmetic; values pass bit-exact, sign preserved. Counters wrap 7->0 only via the block-complete rules above.

Test Plan:
- Reset, then 8 rows with element (r,c) = 8r+c, in_valid=1, out_ready=1 -> out_valid rises 1 cycle after 8th accept. Column c shows qk = 8k+c for c=0..7; out_col steps 0..7; out_last only at col 7.
- Three back-to-back blocks, in_valid=1 and out_ready=1 throughout -> in_ready stays 1. After the first 8-cycle latency, out_valid stays 1 for 24 consecutive cycles and all 24 columns are correct.
- out_ready=0, 17 rows offered -> in_ready drops after the 16th accept and the 17th row is not accepted. Raising out_ready -> 16 correct columns (block A, then B), and the 17th row is accepted the cycle after block A drains.
- Signed extremes: rows alternating -2^22 and 2^22-1 -> identical values appear transposed at q0..q7, bit-exact.
- reset asserted after 5 rows of a block -> next cycle out_valid=0 and in_ready=1. The next 8 rows form a clean block whose 8 columns are correct.
- out_ready toggled every other cycle while streaming 2 blocks -> each column presented exactly once, in order 0..7, and held stable while out_ready=0.
